// File: rtl/usfft_io_ring.sv
// I/O ring: input synchronisers, registered output pads and a boundary-scan chain with update register.
// Optional loopback of PAD_OUT into CORE_IN is compiled in with USFFT_IO_RING_LOOPBACK_EN.
module usfft_io_ring #(
    parameter int IN_W        = 38,
    parameter int OUT_W       = 49,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [IN_W-1:0]  PAD_IN,
    output logic [IN_W-1:0]  CORE_IN,
    input  logic [OUT_W-1:0] CORE_OUT,
    input  logic [OUT_W-1:0] CORE_OE,
    output logic [OUT_W-1:0] PAD_OUT,
    output logic [OUT_W-1:0] PAD_OE,
    input  logic             TEST_EN,
`ifdef USFFT_IO_RING_LOOPBACK_EN
    input  logic             LOOPBACK,
`endif
    input  logic             BS_CAPTURE,
    input  logic             BS_SHIFT,
    input  logic             BS_UPDATE,
    input  logic             BS_SI,
    output logic             BS_SO,
    output logic             BS_BUSY
);

    localparam int CHAIN_W = IN_W + OUT_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_SHIFT   = 2'd2;
    localparam logic [1:0] ST_UPDATE  = 2'd3;

    // Reset asserts asynchronously but releases two edges after RST rises.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_n_int;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n_int = rst_sync_q[1];

    logic [SYNC_STAGES-1:0][IN_W-1:0] sync_q;
    logic [SYNC_STAGES-1:0][IN_W-1:0] sync_d;
    logic [IN_W-1:0]                  sync_last;

    always_comb begin
        sync_d[0] = PAD_IN;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [CHAIN_W-1:0] chain_q;
    logic [CHAIN_W-1:0] chain_d;
    logic [CHAIN_W-1:0] update_q;
    logic [CHAIN_W-1:0] update_d;

    // CAPTURE wins over UPDATE wins over SHIFT when leaving IDLE.
    always_comb begin
        state_d  = state_q;
        chain_d  = chain_q;
        update_d = update_q;
        case (state_q)
            ST_IDLE: begin
                if (BS_CAPTURE) begin
                    state_d = ST_CAPTURE;
                end else if (BS_UPDATE) begin
                    state_d = ST_UPDATE;
                end else if (BS_SHIFT) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_CAPTURE: begin
                chain_d = {CORE_OUT, sync_last};
                state_d = BS_SHIFT ? ST_SHIFT : ST_IDLE;
            end
            ST_SHIFT: begin
                chain_d = {BS_SI, chain_q[CHAIN_W-1:1]};
                if (BS_SHIFT) begin
                    state_d = ST_SHIFT;
                end else if (BS_UPDATE) begin
                    state_d = ST_UPDATE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                update_d = chain_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q  <= ST_IDLE;
            chain_q  <= '0;
            update_q <= '0;
        end else begin
            state_q  <= state_d;
            chain_q  <= chain_d;
            update_q <= update_d;
        end
    end

    assign BS_SO   = chain_q[0];
    assign BS_BUSY = (state_q != ST_IDLE);

    logic [OUT_W-1:0] pad_out_q;
    logic [OUT_W-1:0] pad_out_d;
    logic [OUT_W-1:0] pad_oe_q;
    logic [OUT_W-1:0] pad_oe_d;
    logic             test_en_q;
    logic             test_en_d;

    always_comb begin
        test_en_d = TEST_EN;
        if (TEST_EN) begin
            pad_out_d = update_q[CHAIN_W-1:IN_W];
            pad_oe_d  = '1;
        end else begin
            pad_out_d = CORE_OUT;
            pad_oe_d  = CORE_OE;
        end
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            pad_out_q <= '0;
            pad_oe_q  <= '0;
            test_en_q <= 1'b0;
        end else begin
            pad_out_q <= pad_out_d;
            pad_oe_q  <= pad_oe_d;
            test_en_q <= test_en_d;
        end
    end

    assign PAD_OUT = pad_out_q;
    assign PAD_OE  = pad_oe_q;

    logic [IN_W-1:0] core_func;

`ifdef USFFT_IO_RING_LOOPBACK_EN
    localparam int LB_W = (IN_W < OUT_W) ? IN_W : OUT_W;

    // Extra register puts the looped-back value two cycles behind CORE_OUT.
    logic [LB_W-1:0] loop_q;
    logic [LB_W-1:0] loop_d;

    always_comb begin
        loop_d = pad_out_q[LB_W-1:0];
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            loop_q <= '0;
        end else begin
            loop_q <= loop_d;
        end
    end

    for (genvar gi = 0; gi < IN_W; gi++) begin : g_loop_mux
        if (gi < LB_W) begin : g_lb
            assign core_func[gi] = LOOPBACK ? loop_q[gi] : sync_last[gi];
        end else begin : g_pass
            assign core_func[gi] = sync_last[gi];
        end
    end
`else
    assign core_func = sync_last;
`endif

    assign CORE_IN = test_en_q ? update_q[IN_W-1:0] : core_func;

endmodule

// File: tb/tb_usfft_io_ring.sv
// Directed bench for usfft_io_ring with IN_W=4, OUT_W=4, SYNC_STAGES=2.
// Define USFFT_IO_RING_LOOPBACK_EN to also exercise the loopback path.
module tb_usfft_io_ring;

    logic       clk;
    logic       rst_n;
    logic [3:0] pad_in;
    logic [3:0] core_in;
    logic [3:0] core_out;
    logic [3:0] core_oe;
    logic [3:0] pad_out;
    logic [3:0] pad_oe;
    logic       test_en;
    logic       loopback;
    logic       bs_capture;
    logic       bs_shift;
    logic       bs_update;
    logic       bs_si;
    logic       bs_so;
    logic       bs_busy;

    int vectors = 0;
    int errors  = 0;

    usfft_io_ring #(
        .IN_W        (4),
        .OUT_W       (4),
        .SYNC_STAGES (2)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .PAD_IN     (pad_in),
        .CORE_IN    (core_in),
        .CORE_OUT   (core_out),
        .CORE_OE    (core_oe),
        .PAD_OUT    (pad_out),
        .PAD_OE     (pad_oe),
        .TEST_EN    (test_en),
`ifdef USFFT_IO_RING_LOOPBACK_EN
        .LOOPBACK   (loopback),
`endif
        .BS_CAPTURE (bs_capture),
        .BS_SHIFT   (bs_shift),
        .BS_UPDATE  (bs_update),
        .BS_SI      (bs_si),
        .BS_SO      (bs_so),
        .BS_BUSY    (bs_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Capture {CORE_OUT=3, PAD_IN=C} and shift all 8 bits out, LSB first.
    task automatic scan_out(input string tag);
        logic [7:0] exp_seq;
        exp_seq    = 8'b0011_1100;
        bs_capture = 1'b1;
        bs_shift   = 1'b1;
        step();
        chk({tag, "_busy_cap"}, {7'd0, bs_busy}, 8'd1);
        bs_capture = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_so%0d", tag, i), {7'd0, bs_so}, {7'd0, exp_seq[i]});
            if (i == 7) bs_shift = 1'b0;
            step();
        end
        chk({tag, "_busy_end"}, {7'd0, bs_busy}, 8'd0);
    endtask

    initial begin
        logic [7:0] pat;
        rst_n      = 1'b1;
        pad_in     = 4'hF;
        core_out   = 4'hF;
        core_oe    = 4'hF;
        test_en    = 1'b0;
        loopback   = 1'b0;
        bs_capture = 1'b0;
        bs_shift   = 1'b0;
        bs_update  = 1'b0;
        bs_si      = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) step();
        chk("rst_core_in", {4'd0, core_in}, 8'h0);
        chk("rst_pad_out", {4'd0, pad_out}, 8'h0);
        chk("rst_pad_oe",  {4'd0, pad_oe},  8'h0);
        chk("rst_busy",    {7'd0, bs_busy}, 8'h0);
        chk("rst_so",      {7'd0, bs_so},   8'h0);

        // Release: nothing may change on the first edge afterwards.
        rst_n = 1'b1;
        step();
        chk("rel_edge1_pad_out", {4'd0, pad_out}, 8'h0);
        repeat (4) step();
        chk("rel_pad_out", {4'd0, pad_out}, 8'hF);

        pad_in   = 4'h0;
        core_out = 4'h0;
        core_oe  = 4'h0;
        repeat (3) step();
        chk("idle_core_in", {4'd0, core_in}, 8'h0);

        // Latency: inputs 2 cycles, outputs 1 cycle.
        pad_in   = 4'hA;
        core_out = 4'h5;
        core_oe  = 4'hF;
        step();
        chk("lat_core_in_c1", {4'd0, core_in}, 8'h0);
        chk("lat_pad_out_c1", {4'd0, pad_out}, 8'h5);
        chk("lat_pad_oe_c1",  {4'd0, pad_oe},  8'hF);
        core_out = 4'h9;
        core_oe  = 4'h6;
        step();
        chk("lat_core_in_c2", {4'd0, core_in}, 8'hA);
        chk("oe_pad_out",     {4'd0, pad_out}, 8'h9);
        chk("oe_pad_oe",      {4'd0, pad_oe},  8'h6);

        // Capture and scan out.
        pad_in   = 4'hC;
        core_out = 4'h3;
        core_oe  = 4'hF;
        repeat (3) step();
        scan_out("scan1");

        // Reset in the middle of a shift, after 3 shifts (chain = 07).
        bs_capture = 1'b1;
        bs_shift   = 1'b1;
        step();
        bs_capture = 1'b0;
        step();
        repeat (3) step();
        chk("pre_rst_so", {7'd0, bs_so}, 8'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_core_in", {4'd0, core_in}, 8'h0);
        chk("mid_rst_pad_out", {4'd0, pad_out}, 8'h0);
        chk("mid_rst_pad_oe",  {4'd0, pad_oe},  8'h0);
        chk("mid_rst_busy",    {7'd0, bs_busy}, 8'h0);
        chk("mid_rst_so",      {7'd0, bs_so},   8'h0);
        bs_shift = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("post_rst_busy", {7'd0, bs_busy}, 8'h0);
        chk("post_rst_so",   {7'd0, bs_so},   8'h0);
        scan_out("scan2");

        // Shift B6 in (stray capture mid-shift), then update.
        pat      = 8'hB6;
        core_oe  = 4'h0;
        bs_shift = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            bs_si      = pat[i];
            bs_capture = (i == 3);
            if (i == 7) begin
                bs_shift  = 1'b0;
                bs_update = 1'b1;
            end
            step();
        end
        chk("upd_busy", {7'd0, bs_busy}, 8'h1);
        bs_update = 1'b0;
        bs_si     = 1'b0;
        step();
        chk("upd_idle", {7'd0, bs_busy}, 8'h0);
        chk("upd_func_core_in", {4'd0, core_in}, 8'hC);
        test_en = 1'b1;
        #1;
        chk("ten_before_edge", {4'd0, core_in}, 8'hC);
        step();
        chk("ten_core_in", {4'd0, core_in}, 8'h6);
        chk("ten_pad_out", {4'd0, pad_out}, 8'hB);
        chk("ten_pad_oe",  {4'd0, pad_oe},  8'hF);

        // Load chain with 3C, then CAPTURE+UPDATE together must not update.
        bs_capture = 1'b1;
        step();
        bs_capture = 1'b0;
        step();
        bs_capture = 1'b1;
        bs_update  = 1'b1;
        step();
        bs_capture = 1'b0;
        bs_update  = 1'b0;
        step();
        step();
        chk("prio_core_in", {4'd0, core_in}, 8'h6);
        chk("prio_pad_out", {4'd0, pad_out}, 8'hB);

        test_en = 1'b0;
        step();
        chk("ten_off_core_in", {4'd0, core_in}, 8'hC);
        chk("ten_off_pad_out", {4'd0, pad_out}, 8'h3);
        chk("ten_off_pad_oe",  {4'd0, pad_oe},  8'h0);

`ifdef USFFT_IO_RING_LOOPBACK_EN
        loopback = 1'b1;
        pad_in   = 4'h5;
        core_out = 4'h9;
        step();
        step();
        chk("loop_core_in", {4'd0, core_in}, 8'h9);
        loopback = 1'b0;
        repeat (3) step();
        chk("loop_off_core_in", {4'd0, core_in}, 8'h5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/usfft_io_ring.md
USFFT_IO_RING -- requirements
Module: usfft_io_ring

Interface
REQ-001 Parameter IN_W, default 38; number of input pads registered toward the core.
REQ-002 Parameter OUT_W, default 49; number of output pads driven from the core.
REQ-003 Parameter SYNC_STAGES, default 2; input synchroniser depth, legal range 1..4.
REQ-004 CLK  in  1; single clock, rising edge.
REQ-005 RST  in  1; asynchronous, active-low reset.
REQ-006 PAD_IN  in  IN_W; raw input pad values.
REQ-007 CORE_IN  out  IN_W; synchronised inputs presented to the core.
REQ-008 CORE_OUT  in  OUT_W; core result bits.
REQ-009 CORE_OE  in  OUT_W; per-bit output enable from the core, 1 = drive.
REQ-010 PAD_OUT  out  OUT_W; registered pad drive value.
REQ-011 PAD_OE  out  OUT_W; registered pad enable.
REQ-012 TEST_EN  in  1; 1 = pads and core driven from the boundary update register.
REQ-013 BS_CAPTURE, BS_SHIFT, BS_UPDATE  in  1 each; boundary-scan controls.
REQ-014 BS_SI  in  1; scan data in.
REQ-015 BS_SO  out  1; scan data out, equal to chain bit 0.
REQ-016 BS_BUSY  out  1; high in any state other than IDLE.

Function
REQ-017 Input path: PAD_IN passes through SYNC_STAGES flops; CORE_IN equals PAD_IN delayed by SYNC_STAGES cycles when TEST_EN=0.
REQ-018 Output path: PAD_OUT/PAD_OE equal CORE_OUT/CORE_OE delayed by exactly 1 cycle when TEST_EN=0.
REQ-019 Chain: shift register of IN_W+OUT_W bits; bits [IN_W-1:0] map to inputs, bits [IN_W+OUT_W-1:IN_W] map to outputs.
REQ-020 FSM states: IDLE, CAPTURE, SHIFT, UPDATE.
REQ-021 IDLE -> CAPTURE on BS_CAPTURE; else IDLE -> UPDATE on BS_UPDATE; else IDLE -> SHIFT on BS_SHIFT. Priority is CAPTURE > UPDATE > SHIFT.
REQ-022 CAPTURE (1 cycle): chain loads {CORE_OUT, last synchronised input}; next state SHIFT if BS_SHIFT=1, else IDLE.
REQ-023 SHIFT: each cycle, chain shifts right by 1 with BS_SI entering the MSB; state is held while BS_SHIFT=1; BS_UPDATE goes to UPDATE; otherwise IDLE.
REQ-024 UPDATE (1 cycle): the update register is loaded from the chain; next state IDLE.
REQ-025 Assertion of BS_CAPTURE during SHIFT is ignored until IDLE is reached.
REQ-026 TEST_EN=1: CORE_IN = update[IN_W-1:0]; PAD_OUT = update[IN_W+OUT_W-1:IN_W] registered 1 cycle; PAD_OE = all ones.
REQ-027 TEST_EN toggling takes effect on the next edge; the synchroniser continues sampling PAD_IN regardless of TEST_EN.
REQ-028 Scan length wraps naturally: after IN_W+OUT_W shifts, the original chain MSB has appeared at BS_SO.

Reset
REQ-029 RST low: all synchroniser flops, chain, update register, PAD_OUT and CORE_IN go to 0, PAD_OE goes to 0 (pads tristated), FSM goes to IDLE, BS_BUSY goes to 0.
REQ-030 Reset asserted mid-shift aborts the sequence; after release the FSM is in IDLE and chain contents are 0.
REQ-031 Reset deassertion is synchronised internally; the first state change occurs no earlier than the second CLK edge after release.

Configuration
REQ-032 Macro USFFT_IO_RING_LOOPBACK_EN defined: adds input LOOPBACK (1 bit); when LOOPBACK=1 and TEST_EN=0, CORE_IN[k] = PAD_OUT[k] for k < min(IN_W,OUT_W), and the upper bits follow REQ-017.
REQ-033 Macro undefined: no LOOPBACK port, and the loopback mux is not present.

Verification
REQ-034 Bench parameters: IN_W=4, OUT_W=4, SYNC_STAGES=2.
REQ-035 PAD_IN=4'hA applied at cycle 0 -> CORE_IN=4'hA at cycle 2; CORE_OUT=4'h5 with OE=4'hF -> PAD_OUT=4'h5 and PAD_OE=4'hF one cycle later.
REQ-036 CORE_OUT=4'h3 with PAD_IN settled at 4'hC, then BS_CAPTURE, then 8 SHIFT cycles with BS_SI=0 -> BS_SO sequence (LSB first) 0,0,1,1,1,1,0,0.
REQ-037 Shift 8'hB6 in, then BS_UPDATE, then TEST_EN=1 -> CORE_IN=4'h6, PAD_OUT=4'hB, PAD_OE=4'hF.
REQ-038 RST pulsed low at shift count 3 -> all outputs 0, BS_BUSY=0; a following full capture/shift sequence behaves per REQ-036.
REQ-039 With USFFT_IO_RING_LOOPBACK_EN defined: LOOPBACK=1, CORE_OUT=4'h9 -> CORE_IN=4'h9 two cycles later, independent of PAD_IN.
REQ-040 BS_CAPTURE and BS_UPDATE asserted together in IDLE -> CAPTURE taken and the update register is unchanged.
